// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue/writeback slice: op codes, FSM states,
// and op classification.
package fpu_pkg;

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_CVT_F2I = 4'b0001;
    localparam logic [3:0] OP_CVT_I2F = 4'b0010;
    localparam logic [3:0] OP_MUL     = 4'b0011;
    localparam logic [3:0] OP_CMP     = 4'b0100;
    localparam logic [3:0] OP_MINMAX  = 4'b0101;
    localparam logic [3:0] OP_CLASS   = 4'b0110;
    localparam logic [3:0] OP_NONE    = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Ops that occupy the external datapath for a fixed latency.
    function automatic logic is_arith(input logic [3:0] op);
        return (op <= OP_CLASS);
    endfunction

endpackage

// File: rtl/fpu_lat_lookup.sv
// Combinational op code to datapath latency map; each LAT_* must be 1..7.
module fpu_lat_lookup
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD   = 3,
    parameter int unsigned LAT_CVT   = 2,
    parameter int unsigned LAT_MUL   = 4,
    parameter int unsigned LAT_SMALL = 1
) (
    input  logic [3:0] op_code,
    output logic [2:0] lat
);

    always_comb begin
        lat = 3'd1;
        unique case (op_code)
            OP_ADD:                        lat = 3'(LAT_ADD);
            OP_CVT_F2I, OP_CVT_I2F:        lat = 3'(LAT_CVT);
            OP_MUL:                        lat = 3'(LAT_MUL);
            OP_CMP, OP_MINMAX, OP_CLASS:   lat = 3'(LAT_SMALL);
            default:                       lat = 3'd1;
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback controller: latches one decoded FP op, runs the external
// datapath for its latency, then emits a single registered writeback.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD   = 3,
    parameter int unsigned LAT_CVT   = 2,
    parameter int unsigned LAT_MUL   = 4,
    parameter int unsigned LAT_SMALL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  fpu_decode,
    input  logic        freg_write,
    input  logic        integer_reg_write,
    input  logic        mov_from_freg,
    input  logic        mov_from_ireg,
    input  logic        mov_from_float_result,
    input  logic        mov_int_to_fpu,
    input  logic [4:0]  rd,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic [3:0]  op_code,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_start,
    input  logic [31:0] fpu_result,
    output logic        wb_valid,
    output logic        wb_freg_we,
    output logic        wb_ireg_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal_op
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  lat;
    logic [4:0]  rd_q;
    logic        freg_q, ireg_q;
    logic        accept, enter_wb, start_d, illegal_d;
    logic        wb_freg_d, wb_ireg_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_data_d;

    // Operand-source hints are resolved upstream in src_a; nothing to do here.
    logic unused_flags;
    assign unused_flags = mov_from_float_result ^ mov_int_to_fpu;

    fpu_lat_lookup #(
        .LAT_ADD   (LAT_ADD),
        .LAT_CVT   (LAT_CVT),
        .LAT_MUL   (LAT_MUL),
        .LAT_SMALL (LAT_SMALL)
    ) u_lat (
        .op_code (fpu_decode),
        .lat     (lat)
    );

    assign in_ready = (state_q != S_BUSY);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        illegal_d = 1'b0;
        enter_wb  = 1'b0;
        accept    = in_valid & in_ready;
        wb_freg_d = freg_q & ~ireg_q;
        wb_ireg_d = ireg_q;
        wb_rd_d   = rd_q;
        wb_data_d = fpu_result;
        unique case (state_q)
            S_BUSY: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d  = S_WB;
                    enter_wb = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (is_arith(fpu_decode)) begin
                        state_d = S_BUSY;
                        cnt_d   = lat;
                        start_d = 1'b1;
                    end else if (fpu_decode == OP_NONE && (mov_from_freg || mov_from_ireg)) begin
                        // Moves bypass the latch and write back straight from the inputs.
                        state_d   = S_WB;
                        enter_wb  = 1'b1;
                        wb_freg_d = freg_write & ~integer_reg_write;
                        wb_ireg_d = integer_reg_write;
                        wb_rd_d   = rd;
                        wb_data_d = src_a;
                    end else begin
                        illegal_d = 1'b1;
                    end
                    if (freg_write && integer_reg_write) illegal_d = 1'b1;
                end
            end
        endcase
        if (flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            start_d   = 1'b0;
            illegal_d = 1'b0;
            enter_wb  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_code    <= OP_NONE;
            op_a       <= '0;
            op_b       <= '0;
            rd_q       <= '0;
            freg_q     <= 1'b0;
            ireg_q     <= 1'b0;
            op_start   <= 1'b0;
            illegal_op <= 1'b0;
            wb_valid   <= 1'b0;
            wb_freg_we <= 1'b0;
            wb_ireg_we <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
        end else begin
            op_start   <= start_d;
            illegal_op <= illegal_d;
            wb_valid   <= enter_wb;
            wb_freg_we <= enter_wb & wb_freg_d;
            wb_ireg_we <= enter_wb & wb_ireg_d;
            if (enter_wb) begin
                wb_rd   <= wb_rd_d;
                wb_data <= wb_data_d;
            end
            if (accept && !flush) begin
                op_code <= fpu_decode;
                op_a    <= src_a;
                op_b    <= src_b;
                rd_q    <= rd;
                freg_q  <= freg_write;
                ireg_q  <= integer_reg_write;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with default latencies.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  fpu_decode;
    logic        freg_write, integer_reg_write;
    logic        mov_from_freg, mov_from_ireg, mov_from_float_result, mov_int_to_fpu;
    logic [4:0]  rd;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic [3:0]  op_code;
    logic [31:0] op_a, op_b;
    logic        op_start;
    logic [31:0] fpu_result;
    logic        wb_valid, wb_freg_we, wb_ireg_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_op;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned wb_seen;

    fpu_issue_ctrl #(
        .LAT_ADD   (3),
        .LAT_CVT   (2),
        .LAT_MUL   (4),
        .LAT_SMALL (1)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .fpu_decode            (fpu_decode),
        .freg_write            (freg_write),
        .integer_reg_write     (integer_reg_write),
        .mov_from_freg         (mov_from_freg),
        .mov_from_ireg         (mov_from_ireg),
        .mov_from_float_result (mov_from_float_result),
        .mov_int_to_fpu        (mov_int_to_fpu),
        .rd                    (rd),
        .src_a                 (src_a),
        .src_b                 (src_b),
        .flush                 (flush),
        .op_code               (op_code),
        .op_a                  (op_a),
        .op_b                  (op_b),
        .op_start              (op_start),
        .fpu_result            (fpu_result),
        .wb_valid              (wb_valid),
        .wb_freg_we            (wb_freg_we),
        .wb_ireg_we            (wb_ireg_we),
        .wb_rd                 (wb_rd),
        .wb_data               (wb_data),
        .illegal_op            (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; fpu_decode = 4'hF; freg_write = 1'b0; integer_reg_write = 1'b0;
        mov_from_freg = 1'b0; mov_from_ireg = 1'b0; mov_from_float_result = 1'b0;
        mov_int_to_fpu = 1'b0; rd = '0; src_a = '0; src_b = '0; flush = 1'b0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic fw, input logic iw,
                            input logic [4:0] r, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; fpu_decode = op; freg_write = fw; integer_reg_write = iw;
        rd = r; src_a = a; src_b = b;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        fpu_result = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_op_code", 32'(op_code), 32'hF);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_op_start", 32'(op_start), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        step(); rst_n = 1'b1;

        // MUL, latency 4
        drive_op(4'h3, 1'b1, 1'b0, 5'd5, 32'h3F800000, 32'h40000000);
        fpu_result = 32'h40490FDB;
        step();
        idle_inputs();
        check("mul_op_start", 32'(op_start), 32'd1);
        check("mul_in_ready0", 32'(in_ready), 32'd0);
        check("mul_op_code", 32'(op_code), 32'h3);
        check("mul_op_a", op_a, 32'h3F800000);
        check("mul_op_b", op_b, 32'h40000000);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("mul_busy_start", 32'(op_start), 32'd0);
            check("mul_busy_ready", 32'(in_ready), 32'd0);
            check("mul_busy_wb", 32'(wb_valid), 32'd0);
        end
        step();
        check("mul_wb_valid", 32'(wb_valid), 32'd1);
        check("mul_wb_freg", 32'(wb_freg_we), 32'd1);
        check("mul_wb_ireg", 32'(wb_ireg_we), 32'd0);
        check("mul_wb_rd", 32'(wb_rd), 32'd5);
        check("mul_wb_data", wb_data, 32'h40490FDB);
        check("mul_wb_ready", 32'(in_ready), 32'd1);
        step();
        check("mul_wb_end", 32'(wb_valid), 32'd0);

        // Move from freg to integer register
        drive_op(4'hF, 1'b0, 1'b1, 5'd10, 32'hBF800000, 32'h0);
        mov_from_freg = 1'b1;
        step();
        idle_inputs();
        check("mv_wb_valid", 32'(wb_valid), 32'd1);
        check("mv_wb_ireg", 32'(wb_ireg_we), 32'd1);
        check("mv_wb_freg", 32'(wb_freg_we), 32'd0);
        check("mv_wb_data", wb_data, 32'hBF800000);
        check("mv_wb_rd", 32'(wb_rd), 32'd10);
        check("mv_illegal", 32'(illegal_op), 32'd0);
        check("mv_op_start", 32'(op_start), 32'd0);
        step();
        check("mv_wb_end", 32'(wb_valid), 32'd0);

        // Back-to-back: CMP (L=1) then ADD (L=3) accepted in the WB cycle
        drive_op(4'h4, 1'b1, 1'b0, 5'd3, 32'h1, 32'h2);
        fpu_result = 32'h11111111;
        step();
        check("b2b_start1", 32'(op_start), 32'd1);
        check("b2b_ready1", 32'(in_ready), 32'd0);
        drive_op(4'h0, 1'b1, 1'b0, 5'd7, 32'h5, 32'h6);
        step();
        check("b2b_wb1", 32'(wb_valid), 32'd1);
        check("b2b_rd1", 32'(wb_rd), 32'd3);
        check("b2b_data1", wb_data, 32'h11111111);
        check("b2b_ready_wb", 32'(in_ready), 32'd1);
        fpu_result = 32'h22222222;
        step();
        idle_inputs();
        check("b2b_wb_gap", 32'(wb_valid), 32'd0);
        check("b2b_start2", 32'(op_start), 32'd1);
        check("b2b_op_code2", 32'(op_code), 32'h0);
        step();
        check("b2b_gap_a", 32'(wb_valid), 32'd0);
        step();
        check("b2b_gap_b", 32'(wb_valid), 32'd0);
        step();
        check("b2b_wb2", 32'(wb_valid), 32'd1);
        check("b2b_rd2", 32'(wb_rd), 32'd7);
        check("b2b_data2", wb_data, 32'h22222222);
        step();
        check("b2b_wb2_end", 32'(wb_valid), 32'd0);

        // Flush in 2nd BUSY cycle of ADD
        drive_op(4'h0, 1'b1, 1'b0, 5'd9, 32'h7, 32'h8);
        fpu_result = 32'h99999999;
        step();
        idle_inputs();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_ready", 32'(in_ready), 32'd1);
        check("fl_wb", 32'(wb_valid), 32'd0);
        wb_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (wb_valid) wb_seen++;
        end
        check("fl_no_wb", wb_seen, 32'd0);
        // New CVT op (L=2) after flush
        drive_op(4'h1, 1'b0, 1'b1, 5'd12, 32'hA, 32'hB);
        fpu_result = 32'h00000033;
        step();
        idle_inputs();
        check("fl_new_start", 32'(op_start), 32'd1);
        step();
        check("fl_new_busy", 32'(wb_valid), 32'd0);
        step();
        check("fl_new_wb", 32'(wb_valid), 32'd1);
        check("fl_new_ireg", 32'(wb_ireg_we), 32'd1);
        check("fl_new_rd", 32'(wb_rd), 32'd12);
        check("fl_new_data", wb_data, 32'h00000033);
        step();

        // Flush in the same cycle as an accepted move discards it
        drive_op(4'hF, 1'b1, 1'b0, 5'd4, 32'h12345678, 32'h0);
        mov_from_ireg = 1'b1;
        flush = 1'b1;
        step();
        idle_inputs();
        check("flacc_wb", 32'(wb_valid), 32'd0);
        check("flacc_ready", 32'(in_ready), 32'd1);

        // Illegal: NONE without a move flag
        drive_op(4'hF, 1'b1, 1'b0, 5'd1, 32'h0, 32'h0);
        step();
        idle_inputs();
        check("ill_pulse", 32'(illegal_op), 32'd1);
        check("ill_wb", 32'(wb_valid), 32'd0);
        check("ill_ready", 32'(in_ready), 32'd1);
        step();
        check("ill_pulse_end", 32'(illegal_op), 32'd0);
        check("ill_wb2", 32'(wb_valid), 32'd0);

        // Both write targets: integer wins, illegal pulses
        drive_op(4'h5, 1'b1, 1'b1, 5'd2, 32'h0, 32'h0);
        fpu_result = 32'h0000ABCD;
        step();
        idle_inputs();
        check("both_illegal", 32'(illegal_op), 32'd1);
        check("both_start", 32'(op_start), 32'd1);
        step();
        check("both_wb", 32'(wb_valid), 32'd1);
        check("both_ireg", 32'(wb_ireg_we), 32'd1);
        check("both_freg", 32'(wb_freg_we), 32'd0);
        check("both_illegal_end", 32'(illegal_op), 32'd0);
        step();

        // Async reset mid-MUL
        drive_op(4'h3, 1'b1, 1'b0, 5'd6, 32'hCAFE0000, 32'h0000BEEF);
        fpu_result = 32'h55555555;
        step();
        idle_inputs();
        step();
        rst_n = 1'b0;
        #1;
        check("ar_op_start", 32'(op_start), 32'd0);
        check("ar_op_code", 32'(op_code), 32'hF);
        check("ar_op_a", op_a, 32'd0);
        check("ar_op_b", op_b, 32'd0);
        check("ar_ready", 32'(in_ready), 32'd1);
        check("ar_wb_data", wb_data, 32'd0);
        step();
        rst_n = 1'b1;
        wb_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wb_valid) wb_seen++;
        end
        check("ar_no_wb", wb_seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
